pipeline_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage ARM pipeline. It combines the data-hazard flag from the hazard detector, the EXE-stage branch decision and the MEM-stage memory handshake into per-stage freeze/flush controls. It runs a memory-wait watchdog FSM and keeps saturating performance counters. It sits between the hazard detector, the EXE/MEM stages and the pipeline registers.

---
 rtl/pipeline_stall_ctrl_if.sv | 37 +++
 rtl/pipeline_stall_ctrl.sv | 119 +++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the stall controller and the pipeline:
// hazard/branch/memory status in, freeze/flush controls and counters out.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             hazard_in;
    logic             forward_en;
    logic             exe_mem_read;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             perf_clr;
    logic             freeze_pc;
    logic             flush_if_id;
    logic             flush_id_exe;
    logic             freeze_all;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] memwait_cnt;

    modport master (
        output hazard_in, forward_en, exe_mem_read,
        output branch_taken, mem_req, mem_ready, perf_clr,
        input  freeze_pc, flush_if_id, flush_id_exe,
        input  freeze_all, mem_error,
        input  stall_cnt, flush_cnt, memwait_cnt
    );

    modport slave (
        input  hazard_in, forward_en, exe_mem_read,
        input  branch_taken, mem_req, mem_ready, perf_clr,
        output freeze_pc, flush_if_id, flush_id_exe,
        output freeze_all, mem_error,
        output stall_cnt, flush_cnt, memwait_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: prioritised freeze/flush controls,
// memory-wait watchdog FSM and saturating performance counters.
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic                 clk,
    input logic                 rst,
    pipeline_stall_ctrl_if.slave bus
);

    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERROR
    } state_e;

    state_e          state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

    logic mem_busy;
    logic eff_haz;
    logic sel_flush;
    logic sel_stall;

    assign mem_busy = bus.mem_req & ~bus.mem_ready;
    assign eff_haz  = bus.hazard_in & (~bus.forward_en | bus.exe_mem_read);

    always_comb begin
        bus.freeze_pc    = 1'b0;
        bus.flush_if_id  = 1'b0;
        bus.flush_id_exe = 1'b0;
        bus.freeze_all   = 1'b0;
        sel_flush        = 1'b0;
        sel_stall        = 1'b0;
        if (rst) begin
            bus.freeze_all = 1'b0;
        end else if (state_q == ERROR) begin
            bus.freeze_all = 1'b1;
        end else if (mem_busy) begin
            // EXE is frozen, so a pending branch stays visible until release
            bus.freeze_all = 1'b1;
            bus.freeze_pc  = 1'b1;
        end else if (bus.branch_taken) begin
            bus.flush_if_id  = 1'b1;
            bus.flush_id_exe = 1'b1;
            sel_flush        = 1'b1;
        end else if (eff_haz) begin
            bus.freeze_pc    = 1'b1;
            bus.flush_id_exe = 1'b1;
            sel_stall        = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (!mem_busy) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WC_LAST) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            ERROR:   state_d = ERROR;
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.perf_clr) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            if (sel_stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (sel_flush && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (bus.freeze_all && memwait_cnt_q != '1)
                memwait_cnt_q <= memwait_cnt_q + CNT_W'(1);
        end
    end

    assign bus.mem_error   = (state_q == ERROR) & ~rst;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
    assign bus.memwait_cnt = memwait_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed scenarios plus random stimulus, checked every cycle against a
// busy-run / sticky-error model with saturating integer counters.
module tb_pipeline_stall_ctrl;

    localparam int TO   = 16;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipeline_stall_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_stall_ctrl #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    int m_run;
    bit m_err;
    int m_stall;
    int m_flush;
    int m_mw;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit h, input bit f, input bit e, input bit b,
                         input bit rq, input bit rd, input bit pc, input bit r);
        bus.hazard_in    = h;
        bus.forward_en   = f;
        bus.exe_mem_read = e;
        bus.branch_taken = b;
        bus.mem_req      = rq;
        bus.mem_ready    = rd;
        bus.perf_clr     = pc;
        rst              = r;
    endtask

    // One clock cycle: compare at negedge, advance model at posedge.
    task automatic cycle();
        bit busy, eh;
        int ectl;
        int sel;
        @(negedge clk);
        busy = bus.mem_req && !bus.mem_ready;
        eh   = bus.hazard_in && (!bus.forward_en || bus.exe_mem_read);
        sel  = 0;
        ectl = 0;
        if (rst) ectl = 0;
        else if (m_err) begin ectl = 4'b0001; sel = 1; end
        else if (busy) begin ectl = 4'b1001; sel = 1; end
        else if (bus.branch_taken) begin ectl = 4'b0110; sel = 2; end
        else if (eh) begin ectl = 4'b1010; sel = 3; end
        chk("controls",
            {bus.freeze_pc, bus.flush_if_id, bus.flush_id_exe, bus.freeze_all},
            ectl);
        chk("mem_error", bus.mem_error, (m_err && !rst) ? 1 : 0);
        chk("stall_cnt", bus.stall_cnt, m_stall);
        chk("flush_cnt", bus.flush_cnt, m_flush);
        chk("memwait_cnt", bus.memwait_cnt, m_mw);
        @(posedge clk);
        if (rst) begin
            m_run = 0; m_err = 0;
            m_stall = 0; m_flush = 0; m_mw = 0;
        end else begin
            if (!m_err) begin
                if (busy) begin
                    m_run++;
                    if (m_run == TO) m_err = 1;
                end else begin
                    m_run = 0;
                end
            end
            if (bus.perf_clr) begin
                m_stall = 0; m_flush = 0; m_mw = 0;
            end else begin
                if (sel == 1 && m_mw < CMAX) m_mw++;
                if (sel == 2 && m_flush < CMAX) m_flush++;
                if (sel == 3 && m_stall < CMAX) m_stall++;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            cycle();
        end
    endtask

    initial begin
        m_run = 0; m_err = 0; m_stall = 0; m_flush = 0; m_mw = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        cycle();
        idle(1);
        chk("reset_stall", bus.stall_cnt, 0);
        chk("reset_memwait", bus.memwait_cnt, 0);

        // load-use hazard: forwarding cannot help
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        #1;
        chk("loaduse_ctl", {bus.freeze_pc, bus.flush_id_exe}, 2'b11);
        cycle();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("loaduse_cnt", bus.stall_cnt, 1);
        chk("fwd_no_stall", bus.freeze_pc, 0);
        cycle();
        idle(1);
        chk("fwd_cnt_hold", bus.stall_cnt, 1);

        // branch wins over hazard
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        #1;
        chk("br_ctl", {bus.freeze_pc, bus.flush_if_id, bus.flush_id_exe}, 3'b011);
        cycle();
        idle(1);
        chk("br_flush_cnt", bus.flush_cnt, 1);
        chk("br_stall_cnt", bus.stall_cnt, 0);

        // 5-cycle memory wait with a held branch, released on ready
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 1, 0, 0, 0);
            cycle();
        end
        drive(0, 0, 0, 1, 1, 1, 0, 0);
        #1;
        chk("release_flush", bus.flush_if_id, 1);
        cycle();
        idle(1);
        chk("wait5_memwait", bus.memwait_cnt, 5);
        chk("wait5_flush", bus.flush_cnt, 2);

        // timeout
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        for (int i = 0; i < TO; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0, 0);
            cycle();
        end
        chk("timeout_err", bus.mem_error, 1);
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        cycle();
        chk("err_sticky", bus.mem_error, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        idle(1);
        chk("err_cleared", bus.mem_error, 0);

        // saturation then clear while hazard held
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0);
            cycle();
        end
        chk("stall_sat", bus.stall_cnt, CMAX);
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("clr_then_inc", bus.stall_cnt, 1);

        // reset on 3rd busy cycle, then watchdog must restart from 1
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0, 0);
            cycle();
        end
        drive(0, 0, 0, 0, 1, 0, 0, 1);
        cycle();
        for (int i = 0; i < TO; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0, 0);
            cycle();
        end
        chk("midwait_timeout", bus.mem_error, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        cycle();

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 5,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
